tipi_nib_ctrl: RTL and testbench
================================

# tipi_nib_ctrl

Raspberry Pi-side nibble-bus transaction sequencer for the TIPI board. Decodes 3-nibble transactions clocked by the Pi on `r_clk`/`r_nib` and sequences access to the four TIPI byte registers. TD/TC (TI-written) are snapshotted and shifted out to the Pi; RD/RC (Pi-written) are assembled from two nibbles and committed with a one-cycle write strobe. Sits between the Pi header pins and the TD/TC/RD/RC latches inside `tipi_top`.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `r_clk`/`r_nibrst`/`r_nib_in` synchronisers (≥2)

Ports:
- clk  in  1  fabric clock; all logic is on its rising edge
- r_reset  in  1  reset r_reset, synchronous, active-high
- r_clk  in  1  Pi nibble strobe, asynchronous
- r_nibrst  in  1  Pi transaction abort, asynchronous, level, active-high
- r_nib_in  in  4  nibble from Pi (pad input side)
- r_nib_out  out  4  nibble to Pi
- r_nib_oe  out  1  pad output enable for `r_nib`
- td_q  in  8  current TD latch value
- tc_q  in  8  current TC latch value
- rd_d  out  8  RD register value (held)
- rd_we  out  1  one-cycle RD update strobe
- rc_d  out  8  RC register value (held)
- rc_we  out  1  one-cycle RC update strobe
- busy  out  1  high while a transaction is in progress (state ≠ IDLE)
- err  out  1  sticky illegal-command flag

## Operation
- Command nibble: cmd[3] = 1 read / 0 write; cmd[2] reserved, ignored; cmd[1:0] selects 00 TD, 01 TC, 10 RD, 11 RC.
- Every transaction is exactly 3 `r_clk` rises: command, high nibble, low nibble.
- States: IDLE, RD_HI, RD_LO, WR_HI, WR_LO.
- IDLE + rise: latch cmd.
  - Read: snap ← selected register (TD=td_q, TC=tc_q, RD=rd_d, RC=rc_d); go to RD_HI.
  - Write: go to WR_HI.
- RD_HI: r_nib_out = snap[7:4], oe = 1. On rise, go to RD_LO.
- RD_LO: r_nib_out = snap[3:0], oe = 1. On rise, go to IDLE and set oe = 0.
- WR_HI: on rise, hold[7:4] ← nibble; go to WR_LO.
- WR_LO: on rise, go to IDLE.
  - Target RD: rd_d ← {hold[7:4], nibble}, pulse rd_we.
  - Target RC: rc_d ← {hold[7:4], nibble}, pulse rc_we.
  - Target TD or TC: data is discarded, no strobe, err ← 1.
- Snapshot is taken once, at the command rise. Later changes to td_q/tc_q do not affect the nibbles being shifted out (no tearing).
- Synchronised r_nibrst high: state ← IDLE, oe ← 0, no strobe, err ← 0. Rises are ignored while it is high. It takes priority over a rise in the same cycle.
- r_reset: outputs zeroed; rd_d/rc_d cleared; state ← IDLE.

## Timing
- `r_clk` and `r_nib_in` pass through parallel SYNC_STAGES pipelines. A rise pulse fires in the cycle after the synchronised `r_clk` goes 0→1, which is cycle SYNC_STAGES+1 after the pin edge. The nibble sampled is the synchronised nibble from that same cycle.
- Pi requirement: nibble stable ≥ SYNC_STAGES+1 clk before the `r_clk` rise and until the `r_clk` fall. Minimum `r_clk` high and low time is SYNC_STAGES+1 clk each.
- All outputs are registered; they change in cycle N+1 when the rise pulse is in cycle N.
- Read: first nibble and oe are valid 1 clk after the command rise is detected. The second nibble is valid 1 clk after the next rise. oe drops 1 clk after the third rise.
- rd_we/rc_we: high exactly 1 clk, at N+1 of the third rise. rd_d/rc_d update in the same cycle and then hold.
- err: sets at N+1 of the illegal third rise. Clears only on r_reset or synchronised r_nibrst.
- Reset values: r_nib_out = 0, r_nib_oe = 0, rd_d = 0, rc_d = 0, rd_we = 0, rc_we = 0, busy = 0, err = 0.

## Structure
- Package `tipi_nib_pkg` holds:
  - state enum;
  - register-select codes (SEL_TD = 2'b00, SEL_TC = 2'b01, SEL_RD = 2'b10, SEL_RC = 2'b11);
  - CMD_READ_BIT = 3.
- Sub-module `tipi_sync`: a parameterised-width, SYNC_STAGES-deep flip-flop synchroniser, reset by r_reset. Instanced for `r_clk`, `r_nibrst` and `r_nib_in`.
- Edge detect and the FSM live in `tipi_nib_ctrl`. Pad tristate stays in `tipi_top`.

## Test plan
- Reset: assert r_reset for 2 clk → all outputs 0, busy = 0. Rises during reset → no state change.
- Read TD: td_q = A5, Pi sends cmd 1000 then 2 rises → r_nib_out reads A, then 5; oe high from 1 clk after the cmd rise until 1 clk after the 3rd rise; busy clears with oe.
- Write RC: cmd 0011, nibbles 3, C → rc_d = 3C with rc_we high for exactly 1 clk; rd_we stays 0; rd_d unchanged.
- Illegal write: cmd 0000, nibbles F, F → err = 1; no strobes; rd_d/rc_d unchanged. Then pulse r_nibrst → err = 0.
- Abort: cmd 0010, nibble 7, then r_nibrst high 4 clk → state IDLE, no rd_we. A following write RD of 4, 2 → rd_d = 42.
- Snapshot: tc_q = 55, cmd 1001; after the command rise set tc_q = FF → Pi reads 5, then 5. A following read shows F, F.

Source files
------------

// File: rtl/tipi_nib_pkg.sv
// Shared types and constants for the TIPI Pi-side nibble-bus sequencer.
package tipi_nib_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdHi,
    StRdLo,
    StWrHi,
    StWrLo
  } nib_state_e;

  localparam logic [1:0] SEL_TD = 2'b00;
  localparam logic [1:0] SEL_TC = 2'b01;
  localparam logic [1:0] SEL_RD = 2'b10;
  localparam logic [1:0] SEL_RC = 2'b11;

  localparam int unsigned CMD_READ_BIT = 3;

endpackage

// File: rtl/tipi_sync.sv
// Multi-stage flip-flop synchroniser for asynchronous Pi header inputs.
module tipi_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             r_reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Stages];

  always_ff @(posedge clk) begin
    if (r_reset) begin
      for (int i = 0; i < Stages; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/tipi_nib_ctrl.sv
// Pi-side nibble-bus sequencer: decodes 3-nibble transactions and
// reads/writes the TD/TC/RD/RC byte registers.
module tipi_nib_ctrl
  import tipi_nib_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       r_clk,
  input  logic       r_nibrst,
  input  logic [3:0] r_nib_in,
  output logic [3:0] r_nib_out,
  output logic       r_nib_oe,
  input  logic [7:0] td_q,
  input  logic [7:0] tc_q,
  output logic [7:0] rd_d,
  output logic       rd_we,
  output logic [7:0] rc_d,
  output logic       rc_we,
  output logic       busy,
  output logic       err
);

  logic       rclk_s, nibrst_s;
  logic [3:0] nib_s;

  tipi_sync #(.Width(1), .Stages(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .r_reset (r_reset),
    .d_i     (r_clk),
    .q_o     (rclk_s)
  );

  tipi_sync #(.Width(1), .Stages(SYNC_STAGES)) u_sync_rst (
    .clk     (clk),
    .r_reset (r_reset),
    .d_i     (r_nibrst),
    .q_o     (nibrst_s)
  );

  tipi_sync #(.Width(4), .Stages(SYNC_STAGES)) u_sync_nib (
    .clk     (clk),
    .r_reset (r_reset),
    .d_i     (r_nib_in),
    .q_o     (nib_s)
  );

  nib_state_e state_q, state_d;
  logic       rclk_q1, rclk_q2;
  logic       rise;
  logic [1:0] sel_q, sel_d;
  logic [7:0] snap_q, snap_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] nib_out_q, nib_out_d;
  logic       oe_q, oe_d;
  logic [7:0] rd_reg_q, rd_reg_d;
  logic [7:0] rc_reg_q, rc_reg_d;
  logic       rd_we_q, rd_we_d;
  logic       rc_we_q, rc_we_d;
  logic       err_q, err_d;
  logic [7:0] sel_val;

  // Extra register stage so the rise pulse lands one cycle after the synchronised edge.
  assign rise = rclk_q1 & ~rclk_q2;

  always_comb begin
    sel_val = td_q;
    unique case (nib_s[1:0])
      SEL_TD:  sel_val = td_q;
      SEL_TC:  sel_val = tc_q;
      SEL_RD:  sel_val = rd_reg_q;
      SEL_RC:  sel_val = rc_reg_q;
      default: sel_val = td_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    snap_d    = snap_q;
    hold_d    = hold_q;
    nib_out_d = nib_out_q;
    oe_d      = oe_q;
    rd_reg_d  = rd_reg_q;
    rc_reg_d  = rc_reg_q;
    rd_we_d   = 1'b0;
    rc_we_d   = 1'b0;
    err_d     = err_q;

    if (nibrst_s) begin
      state_d   = StIdle;
      oe_d      = 1'b0;
      nib_out_d = 4'h0;
      err_d     = 1'b0;
    end else if (rise) begin
      unique case (state_q)
        StIdle: begin
          sel_d = nib_s[1:0];
          if (nib_s[CMD_READ_BIT]) begin
            snap_d    = sel_val;
            nib_out_d = sel_val[7:4];
            oe_d      = 1'b1;
            state_d   = StRdHi;
          end else begin
            state_d = StWrHi;
          end
        end
        StRdHi: begin
          nib_out_d = snap_q[3:0];
          state_d   = StRdLo;
        end
        StRdLo: begin
          nib_out_d = 4'h0;
          oe_d      = 1'b0;
          state_d   = StIdle;
        end
        StWrHi: begin
          hold_d  = nib_s;
          state_d = StWrLo;
        end
        StWrLo: begin
          state_d = StIdle;
          unique case (sel_q)
            SEL_RD: begin
              rd_reg_d = {hold_q, nib_s};
              rd_we_d  = 1'b1;
            end
            SEL_RC: begin
              rc_reg_d = {hold_q, nib_s};
              rc_we_d  = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_reset) begin
      state_q   <= StIdle;
      rclk_q1   <= 1'b0;
      rclk_q2   <= 1'b0;
      sel_q     <= 2'b00;
      snap_q    <= 8'h00;
      hold_q    <= 4'h0;
      nib_out_q <= 4'h0;
      oe_q      <= 1'b0;
      rd_reg_q  <= 8'h00;
      rc_reg_q  <= 8'h00;
      rd_we_q   <= 1'b0;
      rc_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rclk_q1   <= rclk_s;
      rclk_q2   <= rclk_q1;
      sel_q     <= sel_d;
      snap_q    <= snap_d;
      hold_q    <= hold_d;
      nib_out_q <= nib_out_d;
      oe_q      <= oe_d;
      rd_reg_q  <= rd_reg_d;
      rc_reg_q  <= rc_reg_d;
      rd_we_q   <= rd_we_d;
      rc_we_q   <= rc_we_d;
      err_q     <= err_d;
    end
  end

  assign r_nib_out = nib_out_q;
  assign r_nib_oe  = oe_q;
  assign rd_d      = rd_reg_q;
  assign rd_we     = rd_we_q;
  assign rc_d      = rc_reg_q;
  assign rc_we     = rc_we_q;
  assign busy      = (state_q != StIdle);
  assign err       = err_q;

endmodule

// File: tb/tb_tipi_nib_ctrl.sv
// Self-checking bench for tipi_nib_ctrl: scripted Pi transactions with
// scoreboard queues for read nibbles and RD/RC write strobes.
module tb_tipi_nib_ctrl;

  localparam int unsigned SyncStages = 2;

  logic       clk = 1'b0;
  logic       r_reset = 1'b1;
  logic       r_clk = 1'b0;
  logic       r_nibrst = 1'b0;
  logic [3:0] r_nib_in = 4'h0;
  logic [3:0] r_nib_out;
  logic       r_nib_oe;
  logic [7:0] td_q = 8'h00;
  logic [7:0] tc_q = 8'h00;
  logic [7:0] rd_d;
  logic       rd_we;
  logic [7:0] rc_d;
  logic       rc_we;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] nib_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] rc_exp_q[$];
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] exp_rc = 8'h00;
  logic       rd_we_prev = 1'b0;
  logic       rc_we_prev = 1'b0;

  tipi_nib_ctrl #(.SYNC_STAGES(SyncStages)) dut (
    .clk       (clk),
    .r_reset   (r_reset),
    .r_clk     (r_clk),
    .r_nibrst  (r_nibrst),
    .r_nib_in  (r_nib_in),
    .r_nib_out (r_nib_out),
    .r_nib_oe  (r_nib_oe),
    .td_q      (td_q),
    .tc_q      (tc_q),
    .rd_d      (rd_d),
    .rd_we     (rd_we),
    .rc_d      (rc_d),
    .rc_we     (rc_we),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Strobe monitor: each strobe pops the expected write and must last one cycle.
  always @(negedge clk) begin
    if (rd_we) begin
      n_checks++;
      if (rd_exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_we_unexpected: got strobe with rd_d=%h, required no strobe", rd_d);
      end else begin
        logic [7:0] e;
        e = rd_exp_q.pop_front();
        if (rd_d !== e) begin
          n_errors++;
          $display("FAIL rd_strobe_data: got %h, required %h", rd_d, e);
        end
      end
      if (rd_we_prev) begin
        n_errors++;
        $display("FAIL rd_we_width: got >1 cycle, required 1 cycle");
      end
    end
    if (rc_we) begin
      n_checks++;
      if (rc_exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rc_we_unexpected: got strobe with rc_d=%h, required no strobe", rc_d);
      end else begin
        logic [7:0] e;
        e = rc_exp_q.pop_front();
        if (rc_d !== e) begin
          n_errors++;
          $display("FAIL rc_strobe_data: got %h, required %h", rc_d, e);
        end
      end
      if (rc_we_prev) begin
        n_errors++;
        $display("FAIL rc_we_width: got >1 cycle, required 1 cycle");
      end
    end
    rd_we_prev = rd_we;
    rc_we_prev = rc_we;
  end

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One Pi strobe; samples outputs the cycle before and the cycle after the rise takes effect.
  task automatic pi_rise(input logic [3:0] nib, output logic oe_b, output logic oe_a,
                         output logic [3:0] nib_a, output logic busy_a, output logic err_a);
    r_nib_in = nib;
    wait_clk(SyncStages + 2);
    r_clk = 1'b1;
    wait_clk(SyncStages + 1);
    oe_b = r_nib_oe;
    wait_clk(1);
    oe_a   = r_nib_oe;
    nib_a  = r_nib_out;
    busy_a = busy;
    err_a  = err;
    wait_clk(2);
    r_clk = 1'b0;
    wait_clk(SyncStages + 4);
  endtask

  task automatic pi_read(input string name, input logic [1:0] sel, input logic [7:0] exp);
    logic ob, oa, ba, ea;
    logic [3:0] na, e;
    nib_q.push_back(exp[7:4]);
    nib_q.push_back(exp[3:0]);
    pi_rise({2'b10, sel}, ob, oa, na, ba, ea);
    e = nib_q.pop_front();
    n_checks++;
    if (ob !== 1'b0 || oa !== 1'b1 || na !== e || ba !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_hi: got oe %b->%b nib %h busy %b, required oe 0->1 nib %h busy 1",
               name, ob, oa, na, ba, e);
    end
    pi_rise(4'h0, ob, oa, na, ba, ea);
    e = nib_q.pop_front();
    n_checks++;
    if (oa !== 1'b1 || na !== e) begin
      n_errors++;
      $display("FAIL %s_lo: got oe %b nib %h, required oe 1 nib %h", name, oa, na, e);
    end
    pi_rise(4'h0, ob, oa, na, ba, ea);
    n_checks++;
    if (ob !== 1'b1 || oa !== 1'b0 || ba !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_end: got oe %b->%b busy %b, required oe 1->0 busy 0", name, ob, oa, ba);
    end
  endtask

  task automatic pi_write(input logic [1:0] sel, input logic [3:0] hi, input logic [3:0] lo,
                          output logic err_a, output logic busy_a);
    logic ob, oa;
    logic [3:0] na;
    if (sel == 2'b10) begin
      rd_exp_q.push_back({hi, lo});
      exp_rd = {hi, lo};
    end else if (sel == 2'b11) begin
      rc_exp_q.push_back({hi, lo});
      exp_rc = {hi, lo};
    end
    pi_rise({2'b00, sel}, ob, oa, na, busy_a, err_a);
    pi_rise(hi, ob, oa, na, busy_a, err_a);
    pi_rise(lo, ob, oa, na, busy_a, err_a);
  endtask

  task automatic pulse_nibrst(input int n);
    r_nibrst = 1'b1;
    wait_clk(n);
    r_nibrst = 1'b0;
    wait_clk(SyncStages + 4);
  endtask

  task automatic test_reset;
    logic ob, oa, ba, ea;
    logic [3:0] na;
    r_reset = 1'b1;
    wait_clk(2);
    n_checks++;
    if ({r_nib_out, r_nib_oe, rd_d, rc_d, rd_we, rc_we, busy, err} !== 25'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got nib %h oe %b rd %h rc %h we %b%b busy %b err %b, required all 0",
               r_nib_out, r_nib_oe, rd_d, rc_d, rd_we, rc_we, busy, err);
    end
    pi_rise(4'b1000, ob, oa, na, ba, ea);
    n_checks++;
    if (oa !== 1'b0 || ba !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_rise_ignored: got oe %b busy %b, required 0 0", oa, ba);
    end
    r_reset = 1'b0;
    wait_clk(4);
    n_checks++;
    if (busy !== 1'b0 || r_nib_oe !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got busy %b oe %b, required 0 0", busy, r_nib_oe);
    end
  endtask

  task automatic test_read_td;
    td_q = 8'hA5;
    pi_read("read_td", 2'b00, 8'hA5);
  endtask

  task automatic test_write_rc;
    logic ea, ba;
    pi_write(2'b11, 4'h3, 4'hC, ea, ba);
    n_checks++;
    if (rc_d !== 8'h3C || rd_d !== exp_rd || ba !== 1'b0 || ea !== 1'b0) begin
      n_errors++;
      $display("FAIL write_rc: got rc %h rd %h busy %b err %b, required rc 3c rd %h busy 0 err 0",
               rc_d, rd_d, ba, ea, exp_rd);
    end
  endtask

  task automatic test_illegal_write;
    logic ea, ba;
    pi_write(2'b00, 4'hF, 4'hF, ea, ba);
    n_checks++;
    if (ea !== 1'b1 || rd_d !== exp_rd || rc_d !== exp_rc) begin
      n_errors++;
      $display("FAIL illegal_write: got err %b rd %h rc %h, required err 1 rd %h rc %h",
               ea, rd_d, rc_d, exp_rd, exp_rc);
    end
    wait_clk(5);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    pulse_nibrst(3);
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_clear: got %b, required 0", err);
    end
  endtask

  task automatic test_abort;
    logic ob, oa, ba, ea;
    logic [3:0] na;
    pi_rise(4'b0010, ob, oa, na, ba, ea);
    pi_rise(4'h7, ob, oa, na, ba, ea);
    n_checks++;
    if (ba !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_busy_before: got %b, required 1", ba);
    end
    pulse_nibrst(4);
    n_checks++;
    if (busy !== 1'b0 || rd_d !== exp_rd) begin
      n_errors++;
      $display("FAIL abort_idle: got busy %b rd %h, required busy 0 rd %h", busy, rd_d, exp_rd);
    end
    pi_write(2'b10, 4'h4, 4'h2, ea, ba);
    n_checks++;
    if (rd_d !== 8'h42) begin
      n_errors++;
      $display("FAIL abort_then_write_rd: got %h, required 42", rd_d);
    end
  endtask

  task automatic test_snapshot;
    logic ob, oa, ba, ea;
    logic [3:0] na;
    tc_q = 8'h55;
    pi_rise(4'b1001, ob, oa, na, ba, ea);
    tc_q = 8'hFF;
    n_checks++;
    if (oa !== 1'b1 || na !== 4'h5) begin
      n_errors++;
      $display("FAIL snap_hi: got oe %b nib %h, required oe 1 nib 5", oa, na);
    end
    pi_rise(4'h0, ob, oa, na, ba, ea);
    n_checks++;
    if (na !== 4'h5) begin
      n_errors++;
      $display("FAIL snap_lo: got nib %h, required 5", na);
    end
    pi_rise(4'h0, ob, oa, na, ba, ea);
    pi_read("snap_reread", 2'b01, 8'hFF);
  endtask

  task automatic test_back_to_back;
    logic ea, ba;
    pi_read("read_rc", 2'b11, exp_rc);
    pi_read("read_rd", 2'b10, exp_rd);
    pi_write(2'b10, 4'h9, 4'hE, ea, ba);
    pi_write(2'b11, 4'h0, 4'h1, ea, ba);
    pi_read("read_rd2", 2'b10, 8'h9E);
    pi_read("read_rc2", 2'b11, 8'h01);
  endtask

  initial begin
    test_reset();
    test_read_td();
    test_write_rc();
    test_illegal_write();
    test_abort();
    test_snapshot();
    test_back_to_back();
    wait_clk(5);
    n_checks++;
    if (rd_exp_q.size() != 0 || rc_exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_strobes: got %0d rd and %0d rc pending, required 0 0",
               rd_exp_q.size(), rc_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
